move_requester: RTL and testbench

Generates the move commands consumed by the piece tracker. It converts level button inputs and an internal gravity timer into a queue of one-pending-bit-per-move requests. It then issues them one at a time on a valid/complete handshake. It sits between the input synchronizers and the tracker in the game datapath.

---
 rtl/tetris_pkg.sv | 33 +++
 rtl/move_requester_if.sv | 13 +
 rtl/btn_edge_repeat.sv | 70 +++++++
 rtl/move_requester.sv | 134 +++++++++++++
 tb/tb_move_requester.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the game datapath: move encoding, requester FSM states and
// small helpers for pending-bit selection.
package tetris_pkg;

    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        ROR   = 3'd2,
        ROL   = 3'd3,
        DOWN  = 3'd4
    } move_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } req_state_t;

    localparam int NUM_MOVES = 5;

    // Pending bits are indexed by the move_t encoding.
    function automatic move_t prio_sel(input logic [NUM_MOVES-1:0] pend);
        if (pend[4]) return DOWN;
        if (pend[2]) return ROR;
        if (pend[3]) return ROL;
        if (pend[1]) return LEFT;
        return RIGHT;
    endfunction

    function automatic logic [NUM_MOVES-1:0] move_onehot(input move_t m);
        return NUM_MOVES'(1) << m;
    endfunction

endpackage

// File: rtl/move_requester_if.sv
// Move handshake between the requester (master) and the piece tracker (slave).
interface move_requester_if;
    import tetris_pkg::*;

    move_t move;
    logic  move_valid;
    logic  complete;
    logic  timeout;

    modport master (output move, output move_valid, output timeout, input complete);
    modport slave  (input move, input move_valid, input timeout, output complete);

endinterface

// File: rtl/btn_edge_repeat.sv
// Registers one synchronized button and emits a one-cycle req on its rising edge.
// Build option: MOVE_REQUESTER_AUTO_REPEAT_EN adds a hold auto-repeat counter.
module btn_edge_repeat
`ifdef MOVE_REQUESTER_AUTO_REPEAT_EN
#(
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = 20,
    parameter int REPEAT_RATE  = 5
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic btn,
    output logic req
);

    logic btn_q;
    logic edge_req;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    assign edge_req = btn & ~btn_q;

`ifdef MOVE_REQUESTER_AUTO_REPEAT_EN
    generate
        if (REPEAT_EN) begin : g_rep
            localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int CW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);

            logic [CW-1:0] cnt;
            logic          armed;
            logic          in_delay;
            logic          rep;

            // First repeat waits REPEAT_DELAY cycles after the edge, later ones REPEAT_RATE.
            assign rep = armed && btn && btn_q &&
                         (cnt == (in_delay ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1)));

            always_ff @(posedge clk) begin
                if (rst || clr || !btn) begin
                    cnt      <= '0;
                    armed    <= 1'b0;
                    in_delay <= 1'b0;
                end else if (edge_req) begin
                    cnt      <= '0;
                    armed    <= 1'b1;
                    in_delay <= 1'b1;
                end else if (rep) begin
                    cnt      <= '0;
                    in_delay <= 1'b0;
                end else if (armed) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign req = edge_req | rep;
        end else begin : g_norep
            assign req = edge_req;
        end
    endgenerate
`else
    assign req = edge_req;
`endif

endmodule

// File: rtl/move_requester.sv
// Turns button edges and a gravity timer into pending move bits and issues them
// one at a time to the tracker. Build option: MOVE_REQUESTER_AUTO_REPEAT_EN.
module move_requester
    import tetris_pkg::*;
#(
    parameter int GRAVITY_CYCLES = 100,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_RATE    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_right,
    input  logic btn_left,
    input  logic btn_ror,
    input  logic btn_rol,
    input  logic btn_down,
    move_requester_if.master trk
);

    // state | meaning
    // IDLE  | nothing presented; loads highest-priority pending move
    // BUSY  | move_valid high, waiting for complete or timeout

    localparam int GW = $clog2(GRAVITY_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    generate
        if (GRAVITY_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cycles
            $error("move_requester: GRAVITY_CYCLES and TIMEOUT_CYCLES must be >= 2");
        end
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
            $error("move_requester: REPEAT_DELAY and REPEAT_RATE must be >= 1");
        end
    endgenerate

    logic [NUM_MOVES-1:0] btn_vec, btn_req, set_vec, clr_vec, pend;
    logic [GW-1:0]        grav_cnt;
    logic                 grav_wrap;
    logic [TW-1:0]        tmo_cnt;
    logic                 tmo_hit;
    req_state_t           state, state_nx;
    logic                 load, done, drop;
    move_t                move_q;
    logic                 timeout_q;

    assign btn_vec = {btn_down, btn_rol, btn_ror, btn_left, btn_right};

    // Only RIGHT (0) and LEFT (1) auto-repeat.
    for (genvar i = 0; i < NUM_MOVES; i++) begin : g_btn
        btn_edge_repeat
`ifdef MOVE_REQUESTER_AUTO_REPEAT_EN
        #(
            .REPEAT_EN    (i < 2),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        )
`endif
        u_btn (
            .clk (clk),
            .rst (rst),
            .clr (!en),
            .btn (btn_vec[i]),
            .req (btn_req[i])
        );
    end

    assign grav_wrap = (grav_cnt == GW'(GRAVITY_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || grav_wrap) grav_cnt <= '0;
        else                         grav_cnt <= grav_cnt + 1'b1;
    end

    assign set_vec = btn_req | {grav_wrap, 4'b0000};

    // A set in the same cycle as the clear wins so the move is reissued.
    always_ff @(posedge clk) begin
        if (rst || !en) pend <= '0;
        else            pend <= (pend & ~clr_vec) | set_vec;
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|pend) state_nx = BUSY;
            BUSY:    if (trk.complete || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!en) state_nx = IDLE;
    end

    always_comb begin
        load    = 1'b0;
        done    = 1'b0;
        drop    = 1'b0;
        clr_vec = '0;
        case (state)
            IDLE: load = en && (|pend);
            BUSY: begin
                done = en && (trk.complete || tmo_hit);
                drop = en && !trk.complete && tmo_hit;
            end
            default: ;
        endcase
        if (done) clr_vec = move_onehot(move_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            move_q    <= RIGHT;
            timeout_q <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            timeout_q <= drop;
            if (load) move_q <= prio_sel(pend);
            if (state == BUSY && state_nx == BUSY) tmo_cnt <= tmo_cnt + 1'b1;
            else                                   tmo_cnt <= '0;
        end
    end

    assign trk.move       = move_q;
    assign trk.move_valid = (state == BUSY);
    assign trk.timeout    = timeout_q;

endmodule

// File: tb/tb_move_requester.sv
// Self-checking bench for move_requester: expected moves are queued when
// buttons are driven and popped as the DUT presents them.
module tb_move_requester;
    import tetris_pkg::*;

`ifdef MOVE_REQUESTER_AUTO_REPEAT_EN
    localparam int EXP_RIGHTS = 5;
`else
    localparam int EXP_RIGHTS = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, en_g = 1'b0, zero = 1'b0;
    logic btn_right = 1'b0, btn_left = 1'b0, btn_ror = 1'b0, btn_rol = 1'b0, btn_down = 1'b0;

    move_requester_if mif();
    move_requester_if gif();

    move_requester #(.GRAVITY_CYCLES(1000), .TIMEOUT_CYCLES(16),
                     .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .btn_right(btn_right), .btn_left(btn_left), .btn_ror(btn_ror),
        .btn_rol(btn_rol), .btn_down(btn_down), .trk(mif));

    move_requester #(.GRAVITY_CYCLES(8), .TIMEOUT_CYCLES(16),
                     .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_g (
        .clk(clk), .rst(rst), .en(en_g),
        .btn_right(zero), .btn_left(zero), .btn_ror(zero),
        .btn_rol(zero), .btn_down(zero), .trk(gif));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_assert = 0;
    int    n_fail   = 0;
    move_t exp_q[$];
    move_t exp_m;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input bit on_g, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((on_g ? gif.move_valid : mif.move_valid) === 1'b1) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic flush();
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mif.complete = 1'b0; gif.complete = 1'b0;
        repeat (3) tick();
        n_assert++; if (mif.move !== RIGHT) begin n_fail++; $display("FAIL reset_move: got %0d expected %0d", mif.move, RIGHT); end
        n_assert++; if (mif.move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", mif.move_valid); end
        n_assert++; if (mif.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", mif.timeout); end
        n_assert++; if (gif.move !== RIGHT || gif.move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_g: got move %0d valid %b expected 0/0", gif.move, gif.move_valid); end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_single_press();
        bit seen;
        flush();
        btn_left = 1'b1; exp_q.push_back(LEFT);
        tick();
        btn_left = 1'b0;
        n_assert++; if (mif.move_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: got valid %b expected 0", mif.move_valid); end
        tick();
        exp_m = exp_q.pop_front();
        n_assert++; if (mif.move_valid !== 1'b1 || mif.move !== exp_m) begin n_fail++; $display("FAIL single_issue: got valid %b move %0d expected 1 %0d", mif.move_valid, mif.move, exp_m); end
        repeat (2) tick();
        n_assert++; if (mif.move_valid !== 1'b1 || mif.move !== LEFT) begin n_fail++; $display("FAIL single_hold: got valid %b move %0d expected 1 %0d", mif.move_valid, mif.move, LEFT); end
        mif.complete = 1'b1;
        tick();
        mif.complete = 1'b0;
        n_assert++; if (mif.move_valid !== 1'b0) begin n_fail++; $display("FAIL single_complete: got valid %b expected 0", mif.move_valid); end
        wait_valid(1'b0, 6, seen);
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL single_no_reissue: got valid %b expected 0", seen); end
    endtask

    task automatic test_priority();
        bit seen;
        flush();
        btn_right = 1'b1; btn_ror = 1'b1; btn_down = 1'b1;
        exp_q.push_back(DOWN); exp_q.push_back(ROR); exp_q.push_back(RIGHT);
        tick();
        btn_right = 1'b0; btn_ror = 1'b0; btn_down = 1'b0;
        wait_valid(1'b0, 10, seen);
        n_assert++; if (seen !== 1'b1) begin n_fail++; $display("FAIL prio_wait: got valid %b expected 1", seen); end
        for (int i = 0; i < 3; i++) begin
            exp_m = exp_q.pop_front();
            n_assert++; if (mif.move_valid !== 1'b1 || mif.move !== exp_m) begin n_fail++; $display("FAIL prio_order[%0d]: got valid %b move %0d expected 1 %0d", i, mif.move_valid, mif.move, exp_m); end
            mif.complete = 1'b1;
            tick();
            mif.complete = 1'b0;
            n_assert++; if (mif.move_valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap[%0d]: got valid %b expected 0", i, mif.move_valid); end
            tick();
        end
        n_assert++; if (mif.move_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL prio_end: got valid %b queue %0d expected 0 0", mif.move_valid, exp_q.size()); end
    endtask

    task automatic test_set_clear();
        bit seen;
        flush();
        btn_left = 1'b1; exp_q.push_back(LEFT); exp_q.push_back(LEFT);
        tick();
        btn_left = 1'b0;
        wait_valid(1'b0, 10, seen);
        exp_m = exp_q.pop_front();
        n_assert++; if (seen !== 1'b1 || mif.move !== exp_m) begin n_fail++; $display("FAIL setclr_first: got seen %b move %0d expected 1 %0d", seen, mif.move, exp_m); end
        mif.complete = 1'b1; btn_left = 1'b1;
        tick();
        mif.complete = 1'b0; btn_left = 1'b0;
        tick();
        exp_m = exp_q.pop_front();
        n_assert++; if (mif.move_valid !== 1'b1 || mif.move !== exp_m) begin n_fail++; $display("FAIL setclr_reissue: got valid %b move %0d expected 1 %0d", mif.move_valid, mif.move, exp_m); end
        mif.complete = 1'b1;
        tick();
        mif.complete = 1'b0;
        wait_valid(1'b0, 6, seen);
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL setclr_extra: got valid %b expected 0", seen); end
    endtask

    task automatic test_timeout();
        bit seen, early;
        int hi;
        flush();
        btn_rol = 1'b1; exp_q.push_back(ROL);
        tick();
        btn_rol = 1'b0;
        wait_valid(1'b0, 10, seen);
        exp_m = exp_q.pop_front();
        n_assert++; if (seen !== 1'b1 || mif.move !== exp_m) begin n_fail++; $display("FAIL tmo_issue: got seen %b move %0d expected 1 %0d", seen, mif.move, exp_m); end
        hi = 0; early = 1'b0;
        while (mif.move_valid === 1'b1 && hi < 40) begin
            if (mif.timeout !== 1'b0) early = 1'b1;
            hi++;
            tick();
        end
        n_assert++; if (hi != 16) begin n_fail++; $display("FAIL tmo_len: got %0d cycles expected 16", hi); end
        n_assert++; if (early !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got pulse %b expected 0", early); end
        n_assert++; if (mif.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b expected 1", mif.timeout); end
        tick();
        n_assert++; if (mif.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_width: got %b expected 0", mif.timeout); end
        wait_valid(1'b0, 8, seen);
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared: got valid %b expected 0", seen); end
    endtask

    task automatic test_flush_reset();
        bit seen;
        flush();
        btn_left = 1'b1; exp_q.push_back(LEFT);
        tick();
        btn_left = 1'b0;
        wait_valid(1'b0, 10, seen);
        exp_m = exp_q.pop_front();
        n_assert++; if (seen !== 1'b1 || mif.move !== exp_m) begin n_fail++; $display("FAIL flush_issue: got seen %b move %0d expected 1 %0d", seen, mif.move, exp_m); end
        btn_ror = 1'b1;
        tick();
        btn_ror = 1'b0; en = 1'b0;
        tick();
        n_assert++; if (mif.move_valid !== 1'b0 || mif.move !== LEFT || mif.timeout !== 1'b0) begin n_fail++; $display("FAIL flush_state: got valid %b move %0d tmo %b expected 0 %0d 0", mif.move_valid, mif.move, mif.timeout, LEFT); end
        en = 1'b1;
        wait_valid(1'b0, 10, seen);
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_request: got valid %b expected 0", seen); end
        btn_left = 1'b1;
        tick();
        btn_left = 1'b0;
        wait_valid(1'b0, 10, seen);
        btn_rol = 1'b1;
        tick();
        btn_rol = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_assert++; if (mif.move !== RIGHT || mif.move_valid !== 1'b0 || mif.timeout !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got move %0d valid %b tmo %b expected %0d 0 0", mif.move, mif.move_valid, mif.timeout, RIGHT); end
        wait_valid(1'b0, 10, seen);
        n_assert++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_request: got valid %b expected 0", seen); end
    endtask

    task automatic test_gravity();
        bit seen;
        int s, rise;
        tick();
        en_g = 1'b1;
        s = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(DOWN);
            wait_valid(1'b1, 20, seen);
            rise  = cyc;
            exp_m = exp_q.pop_front();
            n_assert++; if (seen !== 1'b1 || gif.move !== exp_m) begin n_fail++; $display("FAIL grav_move[%0d]: got seen %b move %0d expected 1 %0d", k, seen, gif.move, exp_m); end
            n_assert++; if (rise != s + 9 + 8 * k) begin n_fail++; $display("FAIL grav_time[%0d]: got cycle %0d expected %0d", k, rise - s, 9 + 8 * k); end
            gif.complete = 1'b1;
            tick();
            gif.complete = 1'b0;
            tick();
        end
        en_g = 1'b0;
    endtask

    task automatic test_auto_repeat();
        bit prev;
        int issued;
        flush();
        for (int i = 0; i < EXP_RIGHTS; i++) exp_q.push_back(RIGHT);
        prev = 1'b0; issued = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.move_valid === 1'b1 && !prev) begin
                issued++;
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rep_extra: got move %0d expected none", mif.move);
                end else begin
                    exp_m = exp_q.pop_front();
                    if (mif.move !== exp_m) begin n_fail++; $display("FAIL rep_move: got %0d expected %0d", mif.move, exp_m); end
                end
            end
            prev = mif.move_valid;
            mif.complete = mif.move_valid;
            btn_right = (i < 12);
            tick();
        end
        mif.complete = 1'b0;
        n_assert++; if (issued != EXP_RIGHTS) begin n_fail++; $display("FAIL rep_count: got %0d expected %0d", issued, EXP_RIGHTS); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_priority();
        test_set_clear();
        test_timeout();
        test_flush_reset();
        test_gravity();
        test_auto_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
